// File: rtl/lcd_scan_output.sv
// lcd_scan_output: parametrised LCD scan-out stage.
// It divides the clock into pixel ticks and runs the H/V timing counters. It
// also aligns sync/DE with an upstream colour source of fixed latency. It
// provides test patterns and drives the backlight PWM.
// Optional: define LCD_SCAN_STATS_EN to build the debug_frames frame counter;
// otherwise debug_frames is tied to zero.
module lcd_scan_output #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FRONT     = 40,
  parameter int H_SYNC      = 48,
  parameter int H_BACK      = 40,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 13,
  parameter int V_SYNC      = 3,
  parameter int V_BACK      = 29,
  parameter int TICK_DIV    = 2,
  parameter int SRC_LATENCY = 1,
  parameter int COLOR_BITS  = 8,
  parameter int PWM_BITS    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    tick,
  output logic [10:0]             x,
  output logic [9:0]              y,
  output logic                    next_frame,
  input  logic [COLOR_BITS-1:0]   src_red,
  input  logic [COLOR_BITS-1:0]   src_green,
  input  logic [COLOR_BITS-1:0]   src_blue,
  input  logic [1:0]              mode,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  input  logic                    display_on,
  input  logic [PWM_BITS-1:0]     backlight,
  output logic [COLOR_BITS-1:0]   lcd_red,
  output logic [COLOR_BITS-1:0]   lcd_green,
  output logic [COLOR_BITS-1:0]   lcd_blue,
  output logic                    lcd_hs_n,
  output logic                    lcd_vs_n,
  output logic                    lcd_de,
  output logic                    lcd_display_on,
  output logic                    lcd_pwm,
  output logic [31:0]             debug_frames
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int PIPE_W  = 6;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_X    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_Y    = 10'(V_ACTIVE);
  localparam logic [10:0] HS_START_X = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END_X   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START_Y = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END_Y   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [10:0]           x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic [1:0]            mode_q, mode_d, mode_eff;
  logic [COLOR_BITS-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                  de_q, de_d, hs_n_q, hs_n_d, vs_n_q, vs_n_d;
  logic                  don_q, don_d, pwm_q, pwm_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;

  logic                  de_raw, hs_raw_n, vs_raw_n;
  logic [2:0]            bar_raw;
  logic [PIPE_W-1:0]     raw_vec, dly_vec;
  logic                  de_dly, hs_dly_n, vs_dly_n;
  logic [2:0]            bar_dly;

  // Pixel tick: the divider wraps at TICK_DIV-1, which is also the tick cycle.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Horizontal and vertical position counters, advanced once per tick.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  assign next_frame = tick && (x_q == '0) && (y_q == '0);

  // Raw timing for the current x/y; the bar index uses comparators against k*H_ACTIVE/8.
  always_comb begin
    de_raw   = (x_q < H_ACT_X) && (y_q < V_ACT_Y);
    hs_raw_n = !((x_q >= HS_START_X) && (x_q < HS_END_X));
    vs_raw_n = !((y_q >= VS_START_Y) && (y_q < VS_END_Y));
    bar_raw  = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({x_q, 3'b000} >= 14'(k * H_ACTIVE)) bar_raw = bar_raw + 3'd1;
    end
  end

  assign raw_vec = {de_raw, hs_raw_n, vs_raw_n, bar_raw};

  generate
    if (SRC_LATENCY == 0) begin : g_no_pipe
      assign dly_vec = raw_vec;
    end else begin : g_pipe
      localparam logic [PIPE_W-1:0] PIPE_RST = 6'b011_000;
      logic [PIPE_W-1:0] pipe_q [SRC_LATENCY];
      logic [PIPE_W-1:0] pipe_d [SRC_LATENCY];

      // Timing shift register: one stage per tick to match the source latency.
      always_comb begin
        pipe_d = pipe_q;
        if (tick) begin
          pipe_d[0] = raw_vec;
          for (int i = 1; i < SRC_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      // Timing shift register storage; blanking values on reset.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < SRC_LATENCY; i++) pipe_q[i] <= PIPE_RST;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign dly_vec = pipe_q[SRC_LATENCY-1];
    end
  endgenerate

  assign {de_dly, hs_dly_n, vs_dly_n, bar_dly} = dly_vec;

  // New mode is taken at the frame start; bypass so the first sampled pixel already uses it.
  assign mode_eff = next_frame ? mode : mode_q;

  // Output colour mux and aligned syncs, registered on tick; blanking is always black.
  always_comb begin
    mode_d  = mode_eff;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    de_d    = de_q;
    hs_n_d  = hs_n_q;
    vs_n_d  = vs_n_q;
    if (tick) begin
      de_d    = de_dly;
      hs_n_d  = hs_dly_n;
      vs_n_d  = vs_dly_n;
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (de_dly) begin
        case (mode_eff)
          2'd0: begin
            red_d   = src_red;
            green_d = src_green;
            blue_d  = src_blue;
          end
          2'd1: begin
            red_d   = solid_rgb[3*COLOR_BITS-1 -: COLOR_BITS];
            green_d = solid_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
            blue_d  = solid_rgb[COLOR_BITS-1:0];
          end
          2'd2: begin
            red_d   = {COLOR_BITS{bar_dly[0]}};
            green_d = {COLOR_BITS{bar_dly[1]}};
            blue_d  = {COLOR_BITS{bar_dly[2]}};
          end
          default: ;
        endcase
      end
    end
  end

  // Backlight PWM on the system clock; full scale forces the output constantly high.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_d     = (&backlight) || (pwm_cnt_q < backlight);
    don_d     = display_on;
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= 2'd3;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      de_q      <= 1'b0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      don_q     <= 1'b0;
      pwm_q     <= 1'b0;
      pwm_cnt_q <= '0;
    end else begin
      div_q     <= div_d;
      x_q       <= x_d;
      y_q       <= y_d;
      mode_q    <= mode_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      de_q      <= de_d;
      hs_n_q    <= hs_n_d;
      vs_n_q    <= vs_n_d;
      don_q     <= don_d;
      pwm_q     <= pwm_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

`ifdef LCD_SCAN_STATS_EN
  logic [31:0] frames_q, frames_d;

  // Frame counter, bumped on every frame start.
  always_comb frames_d = next_frame ? frames_q + 32'd1 : frames_q;

  // Frame counter register.
  always_ff @(posedge clock) begin
    if (reset) frames_q <= '0;
    else       frames_q <= frames_d;
  end

  assign debug_frames = frames_q;
`else
  assign debug_frames = 32'd0;
`endif

  assign x              = x_q;
  assign y              = y_q;
  assign lcd_red        = red_q;
  assign lcd_green      = green_q;
  assign lcd_blue       = blue_q;
  assign lcd_hs_n       = hs_n_q;
  assign lcd_vs_n       = vs_n_q;
  assign lcd_de         = de_q;
  assign lcd_display_on = don_q;
  assign lcd_pwm        = pwm_q;

endmodule

// File: tb/tb_lcd_scan_output.sv
// Bench for lcd_scan_output: a small-timing instance (latency 3) and an 800-wide
// instance (latency 0, TICK_DIV 3), each checked against a scoreboard model.
module tb_lcd_scan_output;

  localparam int SL   = 3;
  localparam int S_HT = 14;
  localparam int S_VT = 7;
  localparam int W_HT = 928;
  localparam int W_VT = 5;
  localparam int W_TD = 3;

`ifdef LCD_SCAN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct { logic de; logic hs_n; logic vs_n; logic [23:0] rgb; } pix_t;
  typedef struct { logic [7:0] bl; int highs; } pwm_vec_t;
  typedef struct { int x0; logic [23:0] rgb; } bar_vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // small instance
  logic        s_rst, s_tick, s_nf, s_hs, s_vs, s_de, s_ldo, s_pwm, s_don;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic [7:0]  s_sr, s_sg, s_sb, s_r, s_g, s_b, s_bl;
  logic [1:0]  s_mode;
  logic [23:0] s_solid;
  logic [31:0] s_dbg;

  // wide instance
  logic        w_rst, w_tick, w_nf, w_hs, w_vs, w_de, w_ldo, w_pwm;
  logic [10:0] w_x;
  logic [9:0]  w_y;
  logic [7:0]  w_r, w_g, w_b;
  logic [1:0]  w_mode;
  logic [31:0] w_dbg;

  lcd_scan_output #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .TICK_DIV(2), .SRC_LATENCY(SL), .COLOR_BITS(8), .PWM_BITS(8)
  ) u_small (
    .clock(clock), .reset(s_rst), .tick(s_tick), .x(s_x), .y(s_y), .next_frame(s_nf),
    .src_red(s_sr), .src_green(s_sg), .src_blue(s_sb), .mode(s_mode), .solid_rgb(s_solid),
    .display_on(s_don), .backlight(s_bl), .lcd_red(s_r), .lcd_green(s_g), .lcd_blue(s_b),
    .lcd_hs_n(s_hs), .lcd_vs_n(s_vs), .lcd_de(s_de), .lcd_display_on(s_ldo),
    .lcd_pwm(s_pwm), .debug_frames(s_dbg)
  );

  lcd_scan_output #(
    .H_ACTIVE(800), .H_FRONT(40), .H_SYNC(48), .H_BACK(40),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .TICK_DIV(W_TD), .SRC_LATENCY(0), .COLOR_BITS(8), .PWM_BITS(8)
  ) u_wide (
    .clock(clock), .reset(w_rst), .tick(w_tick), .x(w_x), .y(w_y), .next_frame(w_nf),
    .src_red(8'h00), .src_green(8'h00), .src_blue(8'h00), .mode(w_mode), .solid_rgb(24'h0),
    .display_on(1'b0), .backlight(8'h00), .lcd_red(w_r), .lcd_green(w_g), .lcd_blue(w_b),
    .lcd_hs_n(w_hs), .lcd_vs_n(w_vs), .lcd_de(w_de), .lcd_display_on(w_ldo),
    .lcd_pwm(w_pwm), .debug_frames(w_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- small-instance model ----------------
  int   s_mx, s_my, s_div, s_frames;
  logic [1:0] s_fmode;
  logic s_sb_en = 1'b0;
  pix_t s_q[$];
  logic [23:0] s_hist[$];

  function automatic logic [23:0] src_of(int px, int py);
    return {8'(px), 8'(py), 8'(px + 16 * py)};
  endfunction

  function automatic pix_t small_pix(int px, int py, logic [1:0] m);
    pix_t p;
    logic [2:0] b;
    b      = 3'(px);
    p.de   = (px < 8) && (py < 4);
    p.hs_n = !(px >= 10 && px < 12);
    p.vs_n = (py != 5);
    p.rgb  = 24'h0;
    if (p.de) begin
      case (m)
        2'd0: p.rgb = src_of(px, py);
        2'd1: p.rgb = s_solid;
        2'd2: p.rgb = {{8{b[0]}}, {8{b[1]}}, {8{b[2]}}};
        default: p.rgb = 24'h0;
      endcase
    end
    return p;
  endfunction

  initial begin : sb_small
    pix_t e;
    forever begin
      @(negedge clock);
      if (s_sb_en) begin
        s_div = (s_div == 1) ? 0 : s_div + 1;
        chk("s_tick", 32'(s_tick), 32'(s_div == 1));
        if (s_div == 1) begin
          chk("s_x", 32'(s_x), s_mx);
          chk("s_y", 32'(s_y), s_my);
          chk("s_next_frame", 32'(s_nf), 32'(s_mx == 0 && s_my == 0));
          chk("s_debug_frames", s_dbg, STATS ? s_frames : 0);
          chk("s_display_on", 32'(s_ldo), 32'(s_don));
          if (s_mx == 0 && s_my == 0) begin
            s_fmode = s_mode;
            s_frames++;
          end
          s_q.push_back(small_pix(s_mx, s_my, s_fmode));
          s_hist.push_back(src_of(s_mx, s_my));
          if (s_hist.size() > SL) {s_sr, s_sg, s_sb} = s_hist.pop_front();
          if (s_q.size() == SL + 2) begin
            e = s_q.pop_front();
            chk("s_lcd_de", 32'(s_de), 32'(e.de));
            chk("s_lcd_hs_n", 32'(s_hs), 32'(e.hs_n));
            chk("s_lcd_vs_n", 32'(s_vs), 32'(e.vs_n));
            chk("s_lcd_rgb", 32'({s_r, s_g, s_b}), 32'(e.rgb));
          end
          if (s_mx == S_HT - 1) begin
            s_mx = 0;
            s_my = (s_my == S_VT - 1) ? 0 : s_my + 1;
          end else begin
            s_mx++;
          end
        end else begin
          chk("s_next_frame_idle", 32'(s_nf), 32'd0);
        end
      end
    end
  end

  // ---------------- wide-instance model ----------------
  bar_vec_t bar_tab[8];
  int   w_mx, w_my, w_div, w_frames;
  logic w_sb_en = 1'b0;
  pix_t w_q[$];

  function automatic pix_t wide_pix(int px, int py);
    pix_t p;
    p.de   = (px < 800) && (py < 2);
    p.hs_n = !(px >= 840 && px < 888);
    p.vs_n = (py != 3);
    p.rgb  = 24'h0;
    if (p.de) begin
      for (int i = 0; i < 8; i++) if (px >= bar_tab[i].x0) p.rgb = bar_tab[i].rgb;
    end
    return p;
  endfunction

  initial begin : sb_wide
    pix_t e;
    forever begin
      @(negedge clock);
      if (w_sb_en) begin
        w_div = (w_div == W_TD - 1) ? 0 : w_div + 1;
        chk("w_tick", 32'(w_tick), 32'(w_div == W_TD - 1));
        if (w_div == W_TD - 1) begin
          chk("w_x", 32'(w_x), w_mx);
          chk("w_y", 32'(w_y), w_my);
          chk("w_next_frame", 32'(w_nf), 32'(w_mx == 0 && w_my == 0));
          w_q.push_back(wide_pix(w_mx, w_my));
          if (w_q.size() == 2) begin
            e = w_q.pop_front();
            chk("w_lcd_de", 32'(w_de), 32'(e.de));
            chk("w_lcd_hs_n", 32'(w_hs), 32'(e.hs_n));
            chk("w_lcd_vs_n", 32'(w_vs), 32'(e.vs_n));
            chk("w_lcd_rgb", 32'({w_r, w_g, w_b}), 32'(e.rgb));
          end
          if (w_mx == W_HT - 1) begin
            w_mx = 0;
            if (w_my == W_VT - 1) begin
              w_my = 0;
              w_frames++;
            end else begin
              w_my++;
            end
          end else begin
            w_mx++;
          end
        end
      end
    end
  end

  task automatic wait_small_frames(input int n);
    int k;
    k = 0;
    while (s_frames < n && k < 5000) begin
      @(negedge clock);
      k++;
    end
    if (s_frames < n) fail_now("wait_small_frames");
  endtask

  task automatic wait_small_line(input int yy);
    int k;
    k = 0;
    while (s_my != yy && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (s_my != yy) fail_now("wait_small_line");
  endtask

  task automatic chk_small_reset(input string tag);
    chk({tag, "_tick"}, 32'(s_tick), 32'd0);
    chk({tag, "_x"}, 32'(s_x), 32'd0);
    chk({tag, "_y"}, 32'(s_y), 32'd0);
    chk({tag, "_next_frame"}, 32'(s_nf), 32'd0);
    chk({tag, "_rgb"}, 32'({s_r, s_g, s_b}), 32'd0);
    chk({tag, "_hs_n"}, 32'(s_hs), 32'd1);
    chk({tag, "_vs_n"}, 32'(s_vs), 32'd1);
    chk({tag, "_de"}, 32'(s_de), 32'd0);
    chk({tag, "_display_on"}, 32'(s_ldo), 32'd0);
    chk({tag, "_pwm"}, 32'(s_pwm), 32'd0);
    chk({tag, "_debug_frames"}, s_dbg, 32'd0);
  endtask

  initial begin : main
    pwm_vec_t pwm_tab[6];
    int cnt, ticks, pulses, k;

    bar_tab[0] = '{0,   24'h000000};
    bar_tab[1] = '{100, 24'hFF0000};
    bar_tab[2] = '{200, 24'h00FF00};
    bar_tab[3] = '{300, 24'hFFFF00};
    bar_tab[4] = '{400, 24'h0000FF};
    bar_tab[5] = '{500, 24'hFF00FF};
    bar_tab[6] = '{600, 24'h00FFFF};
    bar_tab[7] = '{700, 24'hFFFFFF};
    pwm_tab[0] = '{8'd0,   0};
    pwm_tab[1] = '{8'd1,   1};
    pwm_tab[2] = '{8'd64,  64};
    pwm_tab[3] = '{8'd128, 128};
    pwm_tab[4] = '{8'd254, 254};
    pwm_tab[5] = '{8'd255, 256};

    s_rst = 1'b1; w_rst = 1'b1;
    s_mode = 2'd0; s_solid = 24'hA53C0F; s_don = 1'b1; s_bl = 8'd255;
    s_sr = 8'h0; s_sg = 8'h0; s_sb = 8'h0;
    w_mode = 2'd2;

    repeat (4) @(negedge clock);
    chk_small_reset("rst");
    chk("rst_w_tick", 32'(w_tick), 32'd0);
    chk("rst_w_xy", 32'({w_x, w_y}), 32'd0);
    chk("rst_w_de", 32'(w_de), 32'd0);
    chk("rst_w_rgb", 32'({w_r, w_g, w_b}), 32'd0);

    @(negedge clock);
    s_rst = 1'b0; w_rst = 1'b0; s_bl = 8'd64;
    s_div = 0; s_mx = 0; s_my = 0; s_frames = 0; s_fmode = 2'd3;
    w_div = 0; w_mx = 0; w_my = 0; w_frames = 0;
    s_q.delete(); s_hist.delete(); w_q.delete();
    #1;
    s_sb_en = 1'b1; w_sb_en = 1'b1;

    // mode changes mid-frame only take effect on the following frame
    wait_small_frames(2); wait_small_line(2); s_mode = 2'd1;
    wait_small_frames(4); wait_small_line(2); s_mode = 2'd2;
    wait_small_frames(6); wait_small_line(2); s_mode = 2'd3;
    wait_small_frames(7);

    for (int i = 0; i < 6; i++) begin
      s_bl = pwm_tab[i].bl;
      repeat (3) @(negedge clock);
      cnt = 0;
      repeat (256) begin
        @(negedge clock);
        cnt += int'(s_pwm);
      end
      chk($sformatf("pwm_high_count_bl%0d", pwm_tab[i].bl), cnt, pwm_tab[i].highs);
    end

    // one-clock reset in the middle of a line
    s_sb_en = 1'b0;
    k = 0;
    while (!(s_x == 11'd5 && s_y == 10'd2) && k < 500) begin
      @(negedge clock);
      k++;
    end
    if (!(s_x == 11'd5 && s_y == 10'd2)) fail_now("wait_x5_y2");
    s_rst = 1'b1;
    @(negedge clock);
    s_rst = 1'b0;
    chk_small_reset("midrst");
    @(negedge clock);
    chk("midrst_first_tick", 32'(s_tick), 32'd1);
    chk("midrst_first_xy", 32'({s_x, s_y}), 32'd0);
    chk("midrst_first_next_frame", 32'(s_nf), 32'd1);
    chk("midrst_first_rgb", 32'({s_r, s_g, s_b}), 32'd0);
    chk("midrst_first_syncs", 32'({s_de, s_hs, s_vs}), 32'b011);
    chk("midrst_first_debug_frames", s_dbg, 32'd0);

    pulses = 1; ticks = 0; k = 0;
    while (pulses < 3 && k < 1000) begin
      @(negedge clock);
      k++;
      if (s_tick) ticks++;
      if (s_nf) begin
        pulses++;
        chk("frame_period_ticks", ticks, 98);
        ticks = 0;
      end
    end
    if (pulses < 3) fail_now("wait_three_frames");
    @(negedge clock);
    chk("debug_frames_after_3", s_dbg, STATS ? 32'd3 : 32'd0);

    k = 0;
    while (w_frames < 1 && k < 20000) begin
      @(negedge clock);
      k++;
    end
    if (w_frames < 1) fail_now("wait_wide_frame");
    w_sb_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
